// File: rtl/fps_counter_axil.sv
// fps_counter_axil
// Measures the frame rate of an AXI4-Stream video path. Stream beats pass
// straight through unchanged. Every start-of-frame beat (tuser accepted) is
// counted, and once per programmable window (CLK_FREQ cycles) the count is
// latched as frames-per-second. Control and results are exposed through an
// AXI4-Lite slave register bank.
//
// Ports
//   i_axi_clk / i_axi_rst     : sole clock, synchronous reset (active-high,
//                               or active-low when INVERT_AXI_RESET = 1)
//   i_aw* / i_w* / o_b*       : AXI4-Lite write channel (32-bit data, OKAY only)
//   i_ar* / o_r*              : AXI4-Lite read channel
//   i_axis_in_* / o_axis_in_tready   : input video stream
//   o_axis_out_* / i_axis_out_tready : output video stream (combinational copy)
//
// Register map (word index = address[ADDR_WIDTH-1:2])
//   0 CONTROL      RW  bit0 enable, bit1 clear (self-clearing, reads 0)
//   1 STATUS       RO  bit0 enable, bit1 fps_valid
//   2 CLK_FREQ     RW  cycles per window (0 behaves as 1)
//   3 FPS          RO  frames in the last completed window
//   4 FRAME_COUNT  RO  frames so far in the current window (saturating)
//   5 TOTAL_FRAMES RO  frames since enable/clear (wrapping)
//   6 VERSION      RO  0x00010000
module fps_counter_axil #(
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned AXIS_WIDTH       = 8,
  parameter bit          INVERT_AXI_RESET = 1'b0,
  parameter logic [31:0] DEFAULT_CLK_FREQ = 32'd100_000_000
) (
  input  logic                  i_axi_clk,
  input  logic                  i_axi_rst,
  input  logic                  i_awvalid,
  input  logic [ADDR_WIDTH-1:0] i_awaddr,
  output logic                  o_awready,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  input  logic [31:0]           i_wdata,
  input  logic [3:0]            i_wstrb,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  output logic [1:0]            o_bresp,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  output logic [1:0]            o_rresp,
  output logic [31:0]           o_rdata,
  input  logic                  i_axis_in_tuser,
  input  logic                  i_axis_in_tvalid,
  input  logic                  i_axis_in_tlast,
  input  logic [AXIS_WIDTH-1:0] i_axis_in_tdata,
  output logic                  o_axis_in_tready,
  output logic                  o_axis_out_tuser,
  output logic                  o_axis_out_tvalid,
  output logic                  o_axis_out_tlast,
  output logic [AXIS_WIDTH-1:0] o_axis_out_tdata,
  input  logic                  i_axis_out_tready
);

  typedef enum logic [2:0] {
    REG_CONTROL      = 3'd0,
    REG_STATUS       = 3'd1,
    REG_CLK_FREQ     = 3'd2,
    REG_FPS          = 3'd3,
    REG_FRAME_COUNT  = 3'd4,
    REG_TOTAL_FRAMES = 3'd5,
    REG_VERSION      = 3'd6
  } reg_idx_t;

  localparam logic [31:0] VERSION_ID = 32'h0001_0000;

  logic        rst;
  logic        enable;
  logic        fps_valid;
  logic [31:0] clk_freq;
  logic [31:0] cycle_cnt;
  logic [31:0] frame_count;
  logic [31:0] fps;
  logic [31:0] total_frames;
  logic [31:0] freq_m1;
  logic [31:0] ctrl_new;
  logic [31:0] rd_mux;
  logic        frame_event;
  logic        rollover;
  logic        wr_fire;
  logic        rd_fire;
  logic        wr_mapped;
  logic        wr_control;
  logic        wr_freq;
  logic        clear_req;
  logic        unused_addr_bits;

  assign rst = INVERT_AXI_RESET ? ~i_axi_rst : i_axi_rst;

  // Stream path: pure wires, unaffected by enable.
  assign o_axis_out_tuser  = i_axis_in_tuser;
  assign o_axis_out_tvalid = i_axis_in_tvalid;
  assign o_axis_out_tlast  = i_axis_in_tlast;
  assign o_axis_out_tdata  = i_axis_in_tdata;
  assign o_axis_in_tready  = i_axis_out_tready;

  assign frame_event = i_axis_in_tvalid & i_axis_out_tready & i_axis_in_tuser;

  assign o_bresp  = 2'b00;
  assign o_rresp  = 2'b00;
  assign o_wready = o_awready;

  assign unused_addr_bits = ^{i_awaddr[1:0], i_araddr[1:0]};

  function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = cur;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    end
    return r;
  endfunction

  assign wr_fire    = o_awready & i_awvalid & i_wvalid;
  assign rd_fire    = o_arready & i_arvalid;
  assign wr_mapped  = (i_awaddr[ADDR_WIDTH-1:5] == '0);
  assign wr_control = wr_fire & wr_mapped & (i_awaddr[4:2] == REG_CONTROL);
  assign wr_freq    = wr_fire & wr_mapped & (i_awaddr[4:2] == REG_CLK_FREQ);

  // Clear is never stored, so its "old" value in the merge is always 0.
  assign ctrl_new  = apply_strb({31'b0, enable}, i_wdata, i_wstrb);
  assign clear_req = wr_control & ctrl_new[1];

  assign freq_m1  = (clk_freq == '0) ? '0 : clk_freq - 32'd1;
  assign rollover = (cycle_cnt >= freq_m1);

  // Measurement engine. Clear outranks everything; a CLK_FREQ write restarts
  // the window; otherwise the window rolls over and includes this cycle's event.
  always_ff @(posedge i_axi_clk) begin
    if (rst) begin
      enable       <= 1'b0;
      fps_valid    <= 1'b0;
      clk_freq     <= DEFAULT_CLK_FREQ;
      cycle_cnt    <= '0;
      frame_count  <= '0;
      fps          <= '0;
      total_frames <= '0;
    end else begin
      if (wr_control) enable   <= ctrl_new[0];
      if (wr_freq)    clk_freq <= apply_strb(clk_freq, i_wdata, i_wstrb);

      if (clear_req) begin
        cycle_cnt    <= '0;
        frame_count  <= '0;
        fps          <= '0;
        total_frames <= '0;
        fps_valid    <= 1'b0;
      end else if (!enable) begin
        cycle_cnt   <= '0;
        frame_count <= '0;
      end else begin
        if (frame_event) total_frames <= total_frames + 32'd1;
        if (wr_freq) begin
          cycle_cnt   <= '0;
          frame_count <= '0;
        end else if (rollover) begin
          fps         <= (frame_event && frame_count != '1) ? frame_count + 32'd1 : frame_count;
          frame_count <= '0;
          cycle_cnt   <= '0;
          fps_valid   <= 1'b1;
        end else begin
          cycle_cnt <= cycle_cnt + 32'd1;
          if (frame_event && frame_count != '1) frame_count <= frame_count + 32'd1;
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (i_araddr[ADDR_WIDTH-1:5] == '0) begin
      case (i_araddr[4:2])
        REG_CONTROL:      rd_mux = {31'b0, enable};
        REG_STATUS:       rd_mux = {30'b0, fps_valid, enable};
        REG_CLK_FREQ:     rd_mux = clk_freq;
        REG_FPS:          rd_mux = fps;
        REG_FRAME_COUNT:  rd_mux = frame_count;
        REG_TOTAL_FRAMES: rd_mux = total_frames;
        REG_VERSION:      rd_mux = VERSION_ID;
        default:          rd_mux = '0;
      endcase
    end
  end

  // AXI-Lite handshakes. Ready is registered, so it pulses one cycle after
  // the request appears and drops on the handshake edge.
  always_ff @(posedge i_axi_clk) begin
    if (rst) begin
      o_awready <= 1'b0;
      o_bvalid  <= 1'b0;
      o_arready <= 1'b0;
      o_rvalid  <= 1'b0;
      o_rdata   <= '0;
    end else begin
      o_awready <= i_awvalid & i_wvalid & ~o_bvalid & ~o_awready;
      if (wr_fire)                   o_bvalid <= 1'b1;
      else if (o_bvalid && i_bready) o_bvalid <= 1'b0;

      o_arready <= i_arvalid & ~o_rvalid & ~o_arready;
      if (rd_fire) begin
        o_rvalid <= 1'b1;
        o_rdata  <= rd_mux;
      end else if (o_rvalid && i_rready) begin
        o_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fps_counter_axil.sv
module tb_fps_counter_axil;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [AW-1:0] awaddr, araddr;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          arvalid, arready, rvalid, rready;
  logic          in_tuser, in_tvalid, in_tlast, in_tready;
  logic [DW-1:0] in_tdata, out_tdata;
  logic          out_tuser, out_tvalid, out_tlast, out_tready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fps_counter_axil #(
    .ADDR_WIDTH(AW),
    .AXIS_WIDTH(DW),
    .INVERT_AXI_RESET(1'b0),
    .DEFAULT_CLK_FREQ(32'd100_000_000)
  ) dut (
    .i_axi_clk(clk),
    .i_axi_rst(rst),
    .i_awvalid(awvalid),
    .i_awaddr(awaddr),
    .o_awready(awready),
    .i_wvalid(wvalid),
    .o_wready(wready),
    .i_wdata(wdata),
    .i_wstrb(wstrb),
    .o_bvalid(bvalid),
    .i_bready(bready),
    .o_bresp(bresp),
    .i_arvalid(arvalid),
    .o_arready(arready),
    .i_araddr(araddr),
    .o_rvalid(rvalid),
    .i_rready(rready),
    .o_rresp(rresp),
    .o_rdata(rdata),
    .i_axis_in_tuser(in_tuser),
    .i_axis_in_tvalid(in_tvalid),
    .i_axis_in_tlast(in_tlast),
    .i_axis_in_tdata(in_tdata),
    .o_axis_in_tready(in_tready),
    .o_axis_out_tuser(out_tuser),
    .o_axis_out_tvalid(out_tvalid),
    .o_axis_out_tlast(out_tlast),
    .o_axis_out_tdata(out_tdata),
    .i_axis_out_tready(out_tready)
  );

  // Full write: waits for the ready pulse, then takes the response at once.
  // Returns on the falling edge one cycle after the handshake edge.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    int n;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) begin
      checks++; errors++;
      $display("FAIL write_accept addr=%h: awready got 0 want 1", addr);
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) begin
      checks++; errors++;
      $display("FAIL write_resp addr=%h: bvalid got 0 want 1", addr);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) begin
      checks++; errors++;
      $display("FAIL read_accept addr=%h: arready got 0 want 1", addr);
    end
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    if (!rvalid) begin
      checks++; errors++;
      $display("FAIL read_resp addr=%h: rvalid got 0 want 1", addr);
    end
    data = rdata;
    resp = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got aw=%b w=%b b=%b ar=%b r=%b bresp=%b rresp=%b rdata=%h want all 0",
               awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata);
    end
    rst = 1'b0;
    axi_read(32'h18, d, r);
    checks++;
    if (d !== 32'h0001_0000 || r !== 2'b00) begin
      errors++; $display("FAIL version: got %h/%b want 00010000/00", d, r);
    end
    axi_read(32'h08, d, r);
    checks++;
    if (d !== 32'd100_000_000) begin
      errors++; $display("FAIL clk_freq_default: got %0d want 100000000", d);
    end
    axi_read(32'h04, d, r);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL status_reset: got %h want 0", d);
    end
  endtask

  task automatic test_measure();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(32'h08, 32'd100, 4'hF);
    axi_write(32'h00, 32'h1, 4'hF);
    // Beats at i = 0,20,...,220: 5 per 100-cycle window, 12 in total,
    // 2 of them fall into the third (still open) window.
    for (int i = 0; i < 230; i++) begin
      in_tvalid = (i % 20 == 0);
      in_tuser  = (i % 20 == 0);
      in_tdata  = DW'(i);
      @(negedge clk);
    end
    in_tvalid = 1'b0; in_tuser = 1'b0;
    axi_read(32'h0C, d, r);
    checks++;
    if (d !== 32'd5) begin errors++; $display("FAIL fps: got %0d want 5", d); end
    axi_read(32'h04, d, r);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL status_run: got %h want 3", d); end
    axi_read(32'h14, d, r);
    checks++;
    if (d !== 32'd12) begin errors++; $display("FAIL total_frames: got %0d want 12", d); end
    axi_read(32'h10, d, r);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL frame_count: got %0d want 2", d); end
  endtask

  task automatic test_passthrough();
    logic [31:0] d;
    logic [1:0]  r;
    @(negedge clk);
    out_tready = 1'b0;
    in_tvalid = 1'b1; in_tuser = 1'b1; in_tlast = 1'b1; in_tdata = 8'hA5;
    #1;
    checks++;
    if ({in_tready, out_tvalid, out_tuser, out_tlast, out_tdata} !== {1'b0, 1'b1, 1'b1, 1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL passthrough_stall: got tready=%b v=%b u=%b l=%b d=%h want 0 1 1 1 a5",
               in_tready, out_tvalid, out_tuser, out_tlast, out_tdata);
    end
    repeat (10) @(negedge clk);
    out_tready = 1'b1;
    in_tvalid = 1'b0; in_tuser = 1'b0; in_tlast = 1'b0; in_tdata = 8'h3C;
    #1;
    checks++;
    if ({in_tready, out_tvalid, out_tdata} !== {1'b1, 1'b0, 8'h3C}) begin
      errors++;
      $display("FAIL passthrough_idle: got tready=%b v=%b d=%h want 1 0 3c",
               in_tready, out_tvalid, out_tdata);
    end
    axi_read(32'h14, d, r);
    checks++;
    if (d !== 32'd12) begin errors++; $display("FAIL stalled_not_counted: got %0d want 12", d); end
  endtask

  task automatic test_clear();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(32'h00, 32'h3, 4'hF);
    axi_read(32'h0C, d, r);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL clear_fps: got %0d want 0", d); end
    axi_read(32'h14, d, r);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL clear_total: got %0d want 0", d); end
    axi_read(32'h10, d, r);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL clear_frame_count: got %0d want 0", d); end
    axi_read(32'h04, d, r);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL clear_status: got %h want 1", d); end
    axi_read(32'h00, d, r);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL control_readback: got %h want 1", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [1:0]  r;
    int n;
    @(negedge clk);
    awaddr = 32'h08; wdata = 32'h100; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    // Second write presented while the first response is still pending.
    wdata = 32'hFFFF_FFFF; wstrb = 4'h1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
        errors++; $display("FAIL bvalid_hold cyc%0d: got %b/%b want 1/00", i, bvalid, bresp);
      end
      checks++;
      if (awready !== 1'b0 || wready !== 1'b0) begin
        errors++; $display("FAIL second_write_blocked cyc%0d: got aw=%b w=%b want 0 0", i, awready, wready);
      end
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (awready !== 1'b1) begin errors++; $display("FAIL second_write_accept: got %b want 1", awready); end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    axi_read(32'h08, d, r);
    checks++;
    if (d !== 32'h1FF) begin errors++; $display("FAIL wstrb_merge: got %h want 000001ff", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(32'h40, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin
      errors++; $display("FAIL unmapped_read_40: got %h/%b want 0/00", d, r);
    end
    axi_read(32'h1C, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read_1c: got %h want 0", d); end
    axi_write(32'h48, 32'hDEAD_BEEF, 4'hF);
    axi_read(32'h08, d, r);
    checks++;
    if (d !== 32'h1FF) begin errors++; $display("FAIL unmapped_write_ignored: got %h want 000001ff", d); end
  endtask

  task automatic test_rollover_event();
    logic [31:0] d;
    logic [1:0]  r;
    // Window restarts on the write edge E; cycle 9 (the rollover) is sampled
    // at E+10. The task returns just after E+1.
    axi_write(32'h08, 32'd10, 4'hF);
    repeat (8) @(negedge clk);
    in_tvalid = 1'b1; in_tuser = 1'b1;
    @(negedge clk);
    in_tvalid = 1'b0; in_tuser = 1'b0;
    axi_read(32'h0C, d, r);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL rollover_event_fps: got %0d want 1", d); end
  endtask

  initial begin
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    arvalid = 1'b0; rready = 1'b0;
    in_tuser = 1'b0; in_tvalid = 1'b0; in_tlast = 1'b0; in_tdata = '0;
    out_tready = 1'b1;
    rst = 1'b1;
    test_reset();
    test_measure();
    test_passthrough();
    test_clear();
    test_back_to_back();
    test_unmapped();
    test_rollover_event();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fps_counter_axil.md
Name: fps_counter_axil

Overview:
- Measures video frame rate on an AXI4-Stream video path.
- Input stream passes straight through to the output stream. Each start-of-frame beat (tuser) is counted.
- Once per programmable one-second window, the count is latched as frames-per-second.
- Control, configuration and results are accessed through an AXI4-Lite slave register bank.

Parameters:
- ADDR_WIDTH, 32, AXI-Lite address width.
- AXIS_WIDTH, 8, stream tdata width.
- INVERT_AXI_RESET, 0, 0 = i_axi_rst used directly (active-high); 1 = i_axi_rst inverted before internal use.
- DEFAULT_CLK_FREQ, 100000000, reset value of the CLK_FREQ register (clock cycles per second).

Ports:
- i_axi_clk  in  1  sole clock
- i_axi_rst  in  1  reset, synchronous, active-high
- i_awvalid  in  1  write address valid
- i_awaddr  in  ADDR_WIDTH  write byte address
- o_awready  out  1  write address ready
- i_wvalid  in  1  write data valid
- o_wready  out  1  write data ready
- i_wdata  in  32  write data
- i_wstrb  in  4  byte strobes
- o_bvalid  out  1  write response valid
- i_bready  in  1  write response ready
- o_bresp  out  2  write response
- i_arvalid  in  1  read address valid
- o_arready  out  1  read address ready
- i_araddr  in  ADDR_WIDTH  read byte address
- o_rvalid  out  1  read data valid
- i_rready  in  1  read data ready
- o_rresp  out  2  read response
- o_rdata  out  32  read data
- i_axis_in_tuser/tvalid/tlast  in  1  input stream sideband
- i_axis_in_tdata  in  AXIS_WIDTH  input stream data
- o_axis_in_tready  out  1  input stream ready
- o_axis_out_tuser/tvalid/tlast  out  1  output stream sideband
- o_axis_out_tdata  out  AXIS_WIDTH  output stream data
- i_axis_out_tready  in  1  output stream ready

Behaviour:
- Reset: synchronous and active-high, applied on the i_axi_clk edge.
  - Reset values: all AXI ready/valid outputs 0, bresp/rresp 0, rdata 0, counters 0, CONTROL 0, CLK_FREQ = DEFAULT_CLK_FREQ.
  - Reset mid-transaction abandons that transaction.
- Stream path is purely combinational:
  - o_axis_out_{tuser,tvalid,tlast,tdata} = i_axis_in_*.
  - o_axis_in_tready = i_axis_out_tready.
  - No data is dropped or altered, and the path is independent of enable.
- Frame event: i_axis_in_tvalid & o_axis_in_tready & i_axis_in_tuser on the same clock.
- Register map (index = address[ADDR_WIDTH-1:2], 32-bit words):
  - 0 CONTROL, RW: bit0 enable, bit1 clear (self-clearing, reads 0).
  - 1 STATUS, RO: bit0 enable, bit1 fps_valid (set after first completed window).
  - 2 CLK_FREQ, RW: cycles per measurement window; a value of 0 is treated as 1.
  - 3 FPS, RO: frames counted in the last completed window.
  - 4 FRAME_COUNT, RO: frames counted so far in the current window.
  - 5 TOTAL_FRAMES, RO: frames since enable/clear; wraps at 2^32.
  - 6 VERSION, RO: 0x00010000.
  - Other indices: read 0; writes ignored. Response is always OKAY (00).
- Write strobes: only bytes with wstrb=1 are updated.
- Measurement, while enable=1:
  - Cycle counter increments each clock.
  - When the cycle counter reaches CLK_FREQ-1:
    - FPS <= FRAME_COUNT plus the current-cycle frame event.
    - FRAME_COUNT <= 0, cycle counter <= 0, fps_valid <= 1.
  - A frame event on the rollover cycle is credited to the closing window.
- enable=0: cycle counter and FRAME_COUNT held at 0; FPS and TOTAL_FRAMES hold their values.
- Clear (bit1) zeroes the cycle counter, FRAME_COUNT, FPS, TOTAL_FRAMES and fps_valid in the cycle after the write. Enable takes its newly written value.
- Writing CLK_FREQ restarts the window: cycle counter and FRAME_COUNT go to 0.
- Counters are 32-bit. FRAME_COUNT saturates at 0xFFFFFFFF.
- AXI-Lite write:
  - o_awready and o_wready are asserted together for one cycle when i_awvalid & i_wvalid & !o_bvalid.
  - The register updates on that edge.
  - o_bvalid rises the next cycle and holds until i_bready.
  - AW without W (or W without AW) waits; no ready is given alone.
- AXI-Lite read:
  - o_arready is pulsed for one cycle when i_arvalid & !o_rvalid.
  - o_rdata/o_rvalid are registered the next cycle and held stable until i_rready.
- Reads and writes may run concurrently and are independent.

Test Plan:
- Reset, then read VERSION (addr 0x18) -> rdata 0x00010000, rresp 0; read CLK_FREQ (0x08) -> 100000000.
- Write CLK_FREQ=100, CONTROL=1; drive one tuser beat every 20 cycles with out_tready=1 -> after second window, FPS reads 5 and STATUS reads 0x3.
- Hold i_axis_out_tready=0 while tvalid/tuser=1 -> o_axis_in_tready=0, no frames counted, data mirrored on output.
- Write CONTROL=0x3 after frames are counted -> FPS, TOTAL_FRAMES, FRAME_COUNT read 0; STATUS reads 0x1.
- Write with bready held low for 5 cycles -> bvalid stays 1; second AW/W not accepted until the response is taken; write with wstrb=0x1 of 0xFFFFFFFF to CLK_FREQ=0x100 -> reads 0x1FF.
- Read unmapped address 0x40 -> rdata 0, rresp 0; frame event on the rollover cycle with CLK_FREQ=10 -> counted in that window's FPS.
